// File: rtl/mac_sequencer.sv
// mac_sequencer: drives the shared 8x8 signed multiplier through a multiply-accumulate
// job. A job length is taken with start, operand pairs arrive over a valid/ready stream,
// and the wrapped signed sum is returned on a valid/ready result port.
//
// state | meaning
// IDLE  | waiting for start; out_acc keeps the last result
// LOAD  | in_ready high, waiting for an operand pair
// MUL   | operands stable at the multiplier, product captured
// ACC   | product added into the accumulator, pair count decremented
// DONE  | out_valid high, result held until out_ready
module mac_sequencer #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_x,
    input  logic [7:0]       in_y,
    output logic [7:0]       mult_x,
    output logic [7:0]       mult_y,
    input  logic [15:0]      mult_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             overflow
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        ACC  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [7:0]               count;
    logic signed [15:0]       prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic                     ovf_now;

    // A signed size cast sign-extends the 16-bit product to the accumulator width.
    assign prod_ext = ACC_W'(prod);
    assign sum      = acc + prod_ext;
    // Signed overflow: both addends share a sign that the wrapped sum does not.
    assign ovf_now  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != 8'd0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (in_valid && in_ready) begin
                    state_nxt = MUL;
                end
            end
            MUL:  state_nxt = ACC;
            ACC:  state_nxt = (count == 8'd1) ? DONE : LOAD;
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs, all aligned to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            mult_x    <= 8'd0;
            mult_y    <= 8'd0;
            overflow  <= 1'b0;
            count     <= 8'd0;
            prod      <= 16'sd0;
            acc       <= '0;
        end else begin
            busy      <= (state_nxt != IDLE);
            in_ready  <= (state_nxt == LOAD);
            out_valid <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                        count    <= len;
                        if (len == 8'd0) begin
                            out_acc <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        mult_x <= in_x;
                        mult_y <= in_y;
                    end
                end
                MUL: begin
                    prod <= $signed(mult_p);
                end
                ACC: begin
                    acc      <= sum;
                    overflow <= overflow | ovf_now;
                    count    <= count - 8'd1;
                    if (count == 8'd1) begin
                        out_acc <= sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: two instances (24-bit and 16-bit accumulators) share one
// stimulus stream; a job-level model predicts every observable output each cycle.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_x = 8'd0;
    logic [7:0]  in_y = 8'd0;
    logic        out_ready = 1'b0;

    logic        busy_a, in_ready_a, out_valid_a, ovf_a;
    logic [7:0]  mx_a, my_a;
    logic [15:0] mp_a;
    logic [23:0] acc_a;

    logic        busy_b, in_ready_b, out_valid_b, ovf_b;
    logic [7:0]  mx_b, my_b;
    logic [15:0] mp_b;
    logic [15:0] acc_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Combinational stand-in for the shared Booth multiplier.
    function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    assign mp_a = mul8(mx_a, my_a);
    assign mp_b = mul8(mx_b, my_b);

    mac_sequencer #(.ACC_W(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_x(in_x), .in_y(in_y),
        .mult_x(mx_a), .mult_y(my_a), .mult_p(mp_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(acc_a), .overflow(ovf_a)
    );

    mac_sequencer #(.ACC_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_x(in_x), .in_y(in_y),
        .mult_x(mx_b), .mult_y(my_b), .mult_p(mp_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(acc_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v % m;
        if (r < 0) r = r + m;
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    // Job-level model: mode 0 idle, 1 waiting for a pair, 2/3 the two cycles after a
    // pair is taken, 4 result offered. Sums kept as plain integers, wrapped to width.
    int      mode;
    int      left;
    longint  m_acc [2];
    longint  m_out [2];
    bit      m_ov  [2];
    logic [7:0] m_mx, m_my;
    longint  m_prod;
    longint  t;
    int      wid [2] = '{24, 16};

    // Advance the model on each clock edge and on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = 0; left = 0; m_mx = 8'd0; m_my = 8'd0; m_prod = 0;
            for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_out[k] = 0; m_ov[k] = 0; end
        end else begin
            case (mode)
                0: if (start) begin
                    for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_ov[k] = 0; end
                    if (len == 8'd0) begin
                        for (int k = 0; k < 2; k++) m_out[k] = 0;
                        mode = 4;
                    end else begin
                        left = int'(len);
                        mode = 1;
                    end
                end
                1: if (in_valid) begin
                    m_mx = in_x; m_my = in_y;
                    m_prod = longint'($signed(in_x)) * longint'($signed(in_y));
                    mode = 2;
                end
                2: mode = 3;
                3: begin
                    for (int k = 0; k < 2; k++) begin
                        t = m_acc[k] + m_prod;
                        if (t < -(longint'(1) << (wid[k] - 1)) || t > (longint'(1) << (wid[k] - 1)) - 1)
                            m_ov[k] = 1'b1;
                        m_acc[k] = wrap(t, wid[k]);
                    end
                    left = left - 1;
                    if (left == 0) begin
                        for (int k = 0; k < 2; k++) m_out[k] = m_acc[k];
                        mode = 4;
                    end else begin
                        mode = 1;
                    end
                end
                4: if (out_ready) mode = 0;
                default: mode = 0;
            endcase
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_a", busy_a, mode != 0);
            chk("in_ready_a", in_ready_a, mode == 1);
            chk("out_valid_a", out_valid_a, mode == 4);
            chk("out_acc_a", longint'($signed(acc_a)), m_out[0]);
            chk("overflow_a", ovf_a, m_ov[0]);
            chk("mult_x_a", mx_a, m_mx);
            chk("mult_y_a", my_a, m_my);
            chk("busy_b", busy_b, mode != 0);
            chk("in_ready_b", in_ready_b, mode == 1);
            chk("out_valid_b", out_valid_b, mode == 4);
            chk("out_acc_b", longint'($signed(acc_b)), m_out[1]);
            chk("overflow_b", ovf_b, m_ov[1]);
            chk("mult_x_b", mx_b, m_mx);
            chk("mult_y_b", my_b, m_my);
        end
    end

    task automatic wait_ready();
        int w;
        w = 0;
        while (!in_ready_a && w < 50) begin @(negedge clk); w++; end
        chk("in_ready_wait", w < 50, 1);
    endtask

    task automatic run_job(input int n, input int xs[4], input int ys[4],
                           input int gap, input int ostall, input bit poke);
        int w;
        @(negedge clk);
        start = 1'b1; len = 8'(n);
        @(negedge clk);
        start = 1'b0; len = 8'd0;
        for (int i = 0; i < n; i++) begin
            wait_ready();
            repeat (gap) begin
                if (poke) begin start = 1'b1; len = 8'd9; end
                @(negedge clk);
            end
            start = 1'b0; len = 8'd0;
            in_x = 8'(xs[i]); in_y = 8'(ys[i]); in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
        w = 0;
        while (!out_valid_a && w < 50) begin @(negedge clk); w++; end
        chk("out_valid_wait", w < 50, 1);
        repeat (ostall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        bit got;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pair with in_valid held high: result 4 edges from the start edge.
        start = 1'b1; len = 8'd1; in_x = 8'd3; in_y = 8'd5; in_valid = 1'b1;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk); cyc++; #1;
            if (cyc == 1) begin start = 1'b0; len = 8'd0; end
            if (out_valid_a) got = 1'b1;
        end
        in_valid = 1'b0;
        chk("latency_len1", cyc, 4);
        @(negedge clk);
        chk("t1_acc", longint'($signed(acc_a)), 15);
        chk("t1_ovf", ovf_a, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t1_busy_after", busy_a, 0);
        chk("t1_acc_retained", longint'($signed(acc_a)), 15);

        // Signed four-pair job.
        run_job(4, '{-128, 127, -1, 7}, '{-128, -128, 1, -9}, 0, 0, 1'b0);
        chk("t2_acc", longint'($signed(acc_a)), 64);
        chk("t2_acc16", longint'($signed(acc_b)), 64);
        chk("t2_ovf", ovf_a, 0);

        // Input gaps and result back-pressure.
        run_job(2, '{2, 4, 0, 0}, '{3, 5, 0, 0}, 4, 5, 1'b0);
        chk("t3_acc", longint'($signed(acc_a)), 26);

        // Empty job.
        run_job(0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0, 1'b0);
        chk("t4_acc_empty", longint'($signed(acc_a)), 0);

        // Start pulses during a running job are ignored.
        run_job(3, '{10, -5, 1, 0}, '{10, 3, 1, 0}, 2, 0, 1'b1);
        chk("t5_acc", longint'($signed(acc_a)), 86);

        // Overflow in the 16-bit instance only.
        run_job(2, '{-128, -128, 0, 0}, '{-128, -128, 0, 0}, 0, 0, 1'b0);
        chk("t6_acc16", longint'($signed(acc_b)), -32768);
        chk("t6_ovf16", ovf_b, 1);
        chk("t6_acc24", longint'($signed(acc_a)), 32768);
        chk("t6_ovf24", ovf_a, 0);

        // Reset during MUL of the second pair of three.
        @(negedge clk);
        start = 1'b1; len = 8'd3;
        @(negedge clk);
        start = 1'b0; len = 8'd0;
        chk("t7_ovf16_cleared", ovf_b, 0);
        in_x = 8'd1; in_y = 8'd2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_ready();
        in_x = 8'd3; in_y = 8'd4; in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_out_acc", acc_a, 0);
        chk("rst_mult_x", mx_a, 0);
        chk("rst_mult_y", my_a, 0);
        chk("rst_overflow", ovf_b, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Fresh job after reset.
        run_job(1, '{6, 0, 0, 0}, '{-7, 0, 0, 0}, 0, 0, 1'b0);
        chk("t8_acc", longint'($signed(acc_a)), -42);
        chk("t8_acc16", longint'($signed(acc_b)), -42);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
